// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: run-state and next-PC source select.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_RET,
        NPC_CALL,
        NPC_ABS,
        NPC_REL,
        NPC_INC
    } npc_sel_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/handshake bundle between decoder, requester and the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int unsigned D    = 12,
    parameter int unsigned OFFW = 6
);
    logic            req;
    logic            stall;
    logic            halt;
    logic            br_en;
    logic            call_en;
    logic            ret_en;
    logic            rel_en;
    logic [D-1:0]    target;
    logic [OFFW-1:0] rel_off;
    logic [D-1:0]    prog_ctr;
    logic            fetch_valid;
    logic            done;
    logic            busy;
    logic            err_ovf;
    logic            err_udf;

    modport master (
        output req, stall, halt, br_en, call_en, ret_en, rel_en, target, rel_off,
        input  prog_ctr, fetch_valid, done, busy, err_ovf, err_udf
    );

    modport slave (
        input  req, stall, halt, br_en, call_en, ret_en, rel_en, target, rel_off,
        output prog_ctr, fetch_valid, done, busy, err_ovf, err_udf
    );
endinterface

// File: rtl/fetch_sequencer_ret_stack.sv
// Hardware return-address LIFO; push is ignored when full, pop when empty.
module ret_stack #(
    parameter int unsigned D      = 12,
    parameter int unsigned SDEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [D-1:0] i_data,
    output logic [D-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);
    localparam int unsigned SPW = $clog2(SDEPTH + 1);
    localparam int unsigned AW  = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    logic [D-1:0]   r_mem [SDEPTH];
    logic [SPW-1:0] r_sp;
    logic [AW-1:0]  w_wr_idx;
    logic [AW-1:0]  w_rd_idx;
    logic [SPW-1:0] w_sp_m1;

    assign w_sp_m1  = r_sp - 1'b1;
    assign w_wr_idx = AW'(r_sp);
    assign w_rd_idx = AW'(w_sp_m1);
    assign o_full   = (r_sp == SPW'(SDEPTH));
    assign o_empty  = (r_sp == '0);
    assign o_top    = o_empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp  <= '0;
            r_mem <= '{default: '0};
        end else if (i_clr) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
            r_sp            <= r_sp + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_sp <= w_sp_m1;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and run-state owner: start/finish handshake, stall,
// absolute/relative branches and a call/return stack.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned D        = 12,
    parameter int unsigned OFFW     = 6,
    parameter int unsigned SDEPTH   = 4,
    parameter int unsigned START_PC = 0,
    parameter int unsigned HALT_PC  = 128
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.slave   bus
);
    // A HALT_PC outside the D-bit range can never be reached.
    localparam bit           HALT_OK = (HALT_PC < (2 ** D));
    localparam logic [D-1:0] HALT_V  = D'(HALT_PC);
    localparam logic [D-1:0] START_V = D'(START_PC);

    state_t       r_state, w_state_nxt;
    npc_sel_t     w_sel;
    logic [D-1:0] r_pc, w_pc_nxt, w_pc_inc, w_pc_rel, w_stk_top;
    logic         r_ovf, r_udf;
    logic         w_ovf_set, w_udf_set, w_start;
    logic         w_push, w_pop, w_full, w_empty, w_at_halt;

    assign w_pc_inc  = r_pc + 1'b1;
    assign w_pc_rel  = r_pc + D'(signed'(bus.rel_off));
    assign w_at_halt = HALT_OK && (r_pc == HALT_V);

    ret_stack #(.D(D), .SDEPTH(SDEPTH)) u_ret_stack (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_start),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_stk_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = NPC_HOLD;
        w_start     = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ovf_set   = 1'b0;
        w_udf_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                end
            end
            RUN: begin
                if (bus.stall) begin
                    w_sel = NPC_HOLD;
                end else if (bus.halt || w_at_halt) begin
                    w_state_nxt = DONE;
                end else if (bus.ret_en) begin
                    if (w_empty) begin
                        w_udf_set = 1'b1;
                        w_sel     = NPC_INC;
                    end else begin
                        w_pop = 1'b1;
                        w_sel = NPC_RET;
                    end
                end else if (bus.call_en) begin
                    w_push    = !w_full;
                    w_ovf_set = w_full;
                    w_sel     = NPC_CALL;
                end else if (bus.br_en) begin
                    w_sel = NPC_ABS;
                end else if (bus.rel_en) begin
                    w_sel = NPC_REL;
                end else begin
                    w_sel = NPC_INC;
                end
            end
            DONE: begin
                if (!bus.req) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc;
        case (w_sel)
            NPC_RET:           w_pc_nxt = w_stk_top;
            NPC_CALL, NPC_ABS: w_pc_nxt = bus.target;
            NPC_REL:           w_pc_nxt = w_pc_rel;
            NPC_INC:           w_pc_nxt = w_pc_inc;
            default:           w_pc_nxt = r_pc;
        endcase
        if (w_start) w_pc_nxt = START_V;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pc    <= START_V;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ovf   <= !w_start && (r_ovf || w_ovf_set);
            r_udf   <= !w_start && (r_udf || w_udf_set);
        end
    end

    assign bus.prog_ctr    = r_pc;
    assign bus.busy        = (r_state == RUN);
    assign bus.done        = (r_state == DONE);
    assign bus.fetch_valid = (r_state == RUN) && !bus.stall && !w_at_halt;
    assign bus.err_ovf     = r_ovf;
    assign bus.err_udf     = r_udf;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: queue-based reference model compared
// every cycle, plus literal expectations at key points of the program.
module tb_fetch_sequencer;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    fetch_sequencer_if #(.D(12), .OFFW(6)) bus ();
    fetch_sequencer_if #(.D(4),  .OFFW(4)) bus4 ();

    fetch_sequencer #(
        .D(12), .OFFW(6), .SDEPTH(4), .START_PC(0), .HALT_PC(128)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    fetch_sequencer #(
        .D(4), .OFFW(4), .SDEPTH(2), .START_PC(14), .HALT_PC(128)
    ) dut4 (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference model: run-state flags, PC and a queue as the return stack.
    bit          m_busy, m_done, m_ovf, m_udf;
    logic [11:0] m_pc;
    logic [11:0] m_stk[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_ovf = 0; m_udf = 0;
            m_pc = 12'd0;
            m_stk.delete();
        end else if (m_done) begin
            if (!bus.req) m_done = 0;
        end else if (!m_busy) begin
            if (bus.req) begin
                m_busy = 1; m_pc = 12'd0; m_ovf = 0; m_udf = 0;
                m_stk.delete();
            end
        end else if (bus.stall) begin
            m_pc = m_pc;
        end else if (bus.halt || m_pc == 12'd128) begin
            m_busy = 0; m_done = 1;
        end else if (bus.ret_en) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_udf = 1; m_pc = m_pc + 12'd1; end
        end else if (bus.call_en) begin
            if (m_stk.size() < 4) m_stk.push_back(m_pc + 12'd1);
            else m_ovf = 1;
            m_pc = bus.target;
        end else if (bus.br_en) begin
            m_pc = bus.target;
        end else if (bus.rel_en) begin
            m_pc = m_pc + 12'($signed(bus.rel_off));
        end else begin
            m_pc = m_pc + 12'd1;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("model_pc",      32'(bus.prog_ctr),    32'(m_pc));
            chk("model_busy",    32'(bus.busy),        32'(m_busy));
            chk("model_done",    32'(bus.done),        32'(m_done));
            chk("model_ovf",     32'(bus.err_ovf),     32'(m_ovf));
            chk("model_udf",     32'(bus.err_udf),     32'(m_udf));
            chk("model_fvalid",  32'(bus.fetch_valid),
                32'(m_busy && !bus.stall && m_pc != 12'd128));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    logic [11:0] pops [5];

    initial begin
        checks = 0; errors = 0;
        pops = '{12'd103, 12'd102, 12'd101, 12'd7, 12'd8};
        reset_n = 1'b0;
        bus.req = 0; bus.stall = 0; bus.halt = 0; bus.br_en = 0; bus.call_en = 0;
        bus.ret_en = 0; bus.rel_en = 0; bus.target = '0; bus.rel_off = '0;
        bus4.req = 0; bus4.stall = 0; bus4.halt = 0; bus4.br_en = 0; bus4.call_en = 0;
        bus4.ret_en = 0; bus4.rel_en = 0; bus4.target = '0; bus4.rel_off = '0;

        cyc(2);
        chk("rst_pc",   32'(bus.prog_ctr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_fv",   32'(bus.fetch_valid), 0);
        reset_n = 1'b1;
        cyc(1);

        bus.req = 1; bus4.req = 1;
        cyc(1);
        bus.req = 0; bus4.req = 0;
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_pc",   32'(bus.prog_ctr), 0);
        chk("start_fv",   32'(bus.fetch_valid), 1);
        chk("d4_pc14",    32'(bus4.prog_ctr), 14);
        cyc(1);
        chk("seq_pc1",    32'(bus.prog_ctr), 1);
        chk("d4_pc15",    32'(bus4.prog_ctr), 15);
        cyc(1);
        chk("d4_wrap",    32'(bus4.prog_ctr), 0);
        cyc(1);
        chk("seq_pc3",    32'(bus.prog_ctr), 3);
        cyc(2);

        bus.call_en = 1; bus.target = 12'd40;
        cyc(1);
        bus.call_en = 0;
        chk("call_pc40", 32'(bus.prog_ctr), 40);
        bus.ret_en = 1;
        cyc(1);
        bus.ret_en = 0;
        chk("ret_pc6", 32'(bus.prog_ctr), 6);
        chk("ret_noerr", 32'({bus.err_ovf, bus.err_udf}), 0);

        for (int i = 0; i < 5; i++) begin
            bus.call_en = 1; bus.target = 12'(100 + i);
            cyc(1);
            chk("nest_pc",  32'(bus.prog_ctr), 32'(100 + i));
            chk("nest_ovf", 32'(bus.err_ovf), 32'(i == 4));
        end
        bus.call_en = 0;
        for (int i = 0; i < 5; i++) begin
            bus.ret_en = 1;
            cyc(1);
            chk("pop_pc",  32'(bus.prog_ctr), 32'(pops[i]));
            chk("pop_udf", 32'(bus.err_udf), 32'(i == 4));
        end
        bus.ret_en = 0;

        cyc(2);
        chk("pre_rel_pc10", 32'(bus.prog_ctr), 10);
        bus.rel_en = 1; bus.rel_off = 6'b111101;
        cyc(1);
        chk("rel_neg3", 32'(bus.prog_ctr), 7);
        bus.rel_off = 6'd5;
        cyc(1);
        chk("rel_pos5", 32'(bus.prog_ctr), 12);
        bus.br_en = 1; bus.target = 12'd50; bus.rel_off = 6'd1;
        cyc(1);
        chk("br_over_rel", 32'(bus.prog_ctr), 50);
        bus.rel_en = 0; bus.call_en = 1; bus.target = 12'd70;
        cyc(1);
        chk("call_over_br", 32'(bus.prog_ctr), 70);
        bus.call_en = 0; bus.ret_en = 1; bus.target = 12'd90;
        cyc(1);
        chk("ret_over_br", 32'(bus.prog_ctr), 51);
        bus.ret_en = 0;

        bus.stall = 1; bus.halt = 1; bus.br_en = 1; bus.req = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("stall_pc", 32'(bus.prog_ctr), 51);
            chk("stall_fv", 32'(bus.fetch_valid), 0);
            chk("stall_busy", 32'(bus.busy), 1);
        end
        bus.stall = 0;
        cyc(1);
        bus.halt = 0; bus.br_en = 0;
        chk("halt_done", 32'(bus.done), 1);
        chk("halt_pc",   32'(bus.prog_ctr), 51);
        cyc(2);
        chk("done_hold", 32'(bus.done), 1);
        bus.req = 0;
        cyc(1);
        chk("done_drop", 32'(bus.done), 0);
        chk("idle_busy", 32'(bus.busy), 0);

        bus.req = 1;
        cyc(1);
        bus.req = 0;
        chk("restart_clr", 32'({bus.err_ovf, bus.err_udf}), 0);
        bus.br_en = 1; bus.target = 12'd120;
        cyc(1);
        bus.br_en = 0;
        cyc(8);
        chk("auto_pc128", 32'(bus.prog_ctr), 128);
        chk("auto_fv",    32'(bus.fetch_valid), 0);
        cyc(1);
        chk("auto_done",  32'(bus.done), 1);
        chk("auto_hold",  32'(bus.prog_ctr), 128);
        cyc(1);

        bus.req = 1;
        cyc(1);
        bus.req = 0;
        cyc(3);
        bus.call_en = 1; bus.target = 12'd60;
        cyc(1);
        bus.call_en = 0;
        chk("pre_rst_pc", 32'(bus.prog_ctr), 60);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_pc",   32'(bus.prog_ctr), 0);
        chk("async_busy", 32'(bus.busy), 0);
        chk("async_fv",   32'(bus.fetch_valid), 0);
        chk("async_d4pc", 32'(bus4.prog_ctr), 14);
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        bus.req = 1;
        cyc(1);
        bus.req = 0; bus.ret_en = 1;
        cyc(1);
        bus.ret_en = 0;
        chk("lost_stack_udf", 32'(bus.err_udf), 1);
        chk("lost_stack_pc",  32'(bus.prog_ctr), 1);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised successor to the single-cycle core's PC/branch logic; owns the program counter and run-state of the core.
- Adds a start/finish handshake, stall, PC-relative branches, and a hardware call/return stack.
- Sits between the control decoder/ALU flags and the instruction ROM.
- Absolute targets come from the external PC LUT.

Parameters:
D, 12, program counter width
OFFW, 6, signed relative-branch offset width
SDEPTH, 4, return-stack depth (entries, >=1)
START_PC, 0, PC loaded on each start
HALT_PC, 128, PC value that forces completion (auto-halt)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req  in  1  start request; level, held by requester until done seen
stall  in  1  freeze sequencing this cycle
halt  in  1  decoded halt instruction
br_en  in  1  take absolute branch to target
call_en  in  1  absolute call: push return address, jump to target
ret_en  in  1  return: pop stack into PC
rel_en  in  1  take relative branch by rel_off
target  in  D  absolute target from PC LUT
rel_off  in  OFFW  signed two's-complement offset
prog_ctr  out  D  current fetch address
fetch_valid  out  1  prog_ctr is a live fetch this cycle
done  out  1  program finished
busy  out  1  state is RUN
err_ovf  out  1  sticky: call with stack full
err_udf  out  1  sticky: return with stack empty

Behaviour:
- Reset is asynchronous on the falling edge of reset; release is synchronous to clk.
- Reset values: state=IDLE, prog_ctr=START_PC, sp=0, stack entries=0, done=0, busy=0, fetch_valid=0, err_ovf=0, err_udf=0.
- FSM states:
  - IDLE: on req=1, go to RUN next edge. Load prog_ctr=START_PC, clear sp, err_ovf and err_udf.
  - RUN: busy=1; fetch_valid = !stall.
  - DONE: done=1; prog_ctr holds. When req=0, go to IDLE next edge; done drops in that same edge.
- RUN next-PC priority, highest first:
  1. stall: hold all state; every other input is ignored, including halt.
  2. halt=1 or prog_ctr==HALT_PC: go to DONE; prog_ctr holds. HALT_PC is checked on the current PC, so the instruction at HALT_PC is never fetched as valid.
  3. ret_en: if sp>0, pop: prog_ctr=stack[sp-1], sp--. If sp==0, set err_udf and prog_ctr=prog_ctr+1.
  4. call_en: if sp<SDEPTH, push prog_ctr+1, sp++. If sp==SDEPTH, set err_ovf and drop the push. The jump to target is taken in both cases.
  5. br_en: prog_ctr=target.
  6. rel_en: prog_ctr = prog_ctr + sign-extended rel_off, modulo 2^D.
  7. Otherwise prog_ctr=prog_ctr+1, modulo 2^D (wraps from all-ones to 0).
- Simultaneous control inputs resolve strictly by the priority above; a lower-priority input asserted together with a higher one is discarded with no side effect.
- Return addresses are computed modulo 2^D.
- Error flags are sticky until the next start from IDLE.
- Latency: one-cycle redirect. Control inputs sampled at edge N set prog_ctr after edge N; there are no delay slots.
- req deasserted during RUN is ignored; the program runs to completion.
- Reset mid-RUN: immediate return to reset values; stack contents are lost.

Decomposition:
- Shared package fetch_pkg:
  - typedef state_t {IDLE, RUN, DONE}.
  - Next-PC select enum {NPC_HOLD, NPC_RET, NPC_CALL, NPC_ABS, NPC_REL, NPC_INC}.
- One sub-module: ret_stack, a parametrised LIFO of SDEPTH x D with push/pop/full/empty and async active-low reset.
- The FSM and next-PC mux stay in fetch_sequencer.

Test Plan:
- Reset low, then release; req=1 for 1 cycle -> busy=1 next cycle, prog_ctr=0,1,2,3 on successive edges, fetch_valid=1.
- At PC 5: call_en, target=40; at 40: ret_en -> prog_ctr 5->40->6; sp returns to 0; no error flags.
- SDEPTH=4: five nested calls -> err_ovf=1 on the 5th, jump still taken. Then five returns -> 4 correct pops, 5th sets err_udf, prog_ctr increments.
- At PC 10: rel_off=-3 with rel_en=1 -> prog_ctr=7. D=4 at PC 15 with no control -> prog_ctr=0 (wrap).
- stall=1 together with halt and br_en for 3 cycles -> prog_ctr frozen, fetch_valid=0. Release stall with halt=1 -> DONE, done=1. Hold req=1 -> done stays 1; drop req -> IDLE, done=0.
- Run until PC=128 with no halt -> DONE on that edge. Assert reset low mid-run -> outputs at reset values within the same cycle, without waiting for a clock edge.
